weight_mux_sequencer: RTL and testbench
=======================================

// Module: weight_mux_sequencer
// PURPOSE
//  Sequences the weight-side mux register for one weight tile. Per tile:
//   - fetches NUM words from the weight buffer;
//   - holds each 32-bit word stable on the mux register's buffer input;
//   - steps the mux 2-bit state through the phases required by the latched input bitwidth.
//  Sits between the weight buffer read port and the weight mux register.
//  Provides a valid flag aligned to the mux register's registered output, with PE-array backpressure.
// PARAMETERS
//  ADDR_W   8   weight buffer address width; also word-count width
// PORTS
//  clk            in   1       system clock, rising edge
//  reset          in   1       asynchronous, active-low reset
//  start          in   1       1-cycle pulse; begins a tile (ignored unless IDLE)
//  base_addr      in   ADDR_W  first buffer address of tile, sampled on start
//  num_words      in   ADDR_W  words in tile, sampled on start
//  input_bitwidth in   2       00=8b, 01=4b, 10/11=2b; sampled on start
//  buf_rd_en      out  1       buffer read request, held until buf_rd_valid
//  buf_rd_addr    out  ADDR_W  buffer read address
//  buf_rd_valid   in   1       read data valid (any latency >=1 cycle after buf_rd_en)
//  buf_rd_data    in   32      read data
//  mux_buffer     out  32      held word driven to mux register buffer input
//  mux_state      out  2       phase driven to mux register state input
//  mux_bitwidth   out  2       latched bitwidth driven to mux register
//  pe_ready       in   1       PE array accepts a sorted word this cycle
//  sorted_valid   out  1       mux register output valid this cycle
//  busy           out  1       high in any state except IDLE
//  done           out  1       1-cycle pulse at tile end
// BEHAVIOUR
//  Reset: all outputs 0 and FSM = IDLE. Reset mid-tile aborts with no done pulse.
//  Phases per word P: bitwidth 00 -> 1 (state 0); 01 -> 2 (0,1); 10/11 -> 4 (0,1,2,3).
//  IDLE:
//   - start=1 & num_words!=0 -> FETCH; latch cfg; addr=base_addr; word_cnt=0.
//   - start=1 & num_words==0 -> DONE; no read is issued.
//  FETCH:
//   - buf_rd_en=1, buf_rd_addr=addr.
//   - On buf_rd_valid: mux_buffer<=buf_rd_data, phase<=0, go to ISSUE.
//   - buf_rd_valid outside FETCH is ignored.
//  ISSUE:
//   - mux_state=phase; issue=pe_ready.
//   - pe_ready=0: phase and mux_buffer hold; issue=0.
//   - pe_ready=1 & phase<P-1: phase++.
//   - pe_ready=1 & phase==P-1 & word_cnt<num_words-1: addr++ (wraps mod 2^ADDR_W), word_cnt++, go to FETCH.
//   - pe_ready=1 & phase==P-1 & last word: go to DONE.
//  DONE: done=1 for one cycle -> IDLE.
//  sorted_valid = issue registered one cycle (the mux register's 1-cycle latency). sorted_valid count per tile = num_words*P.
//  mux_state and mux_buffer are held outside ISSUE. Invalid cycles are flagged by sorted_valid=0.
//  start while busy: ignored; cfg inputs changing mid-tile: ignored.
//  Throughput: P issue cycles per word, plus fetch cycles (read latency + 1).
// TESTING
//  1. bw=00, num=3, base=0x10, 1-cycle read latency, pe_ready=1:
//     - reads 0x10..0x12;
//     - 3 sorted_valid pulses, all with mux_state=0;
//     - done once.
//  2. bw=01, num=1, word 0xDDCCBBAA:
//     - mux_state 0,1;
//     - sorted outputs 0xBBBBAAAA then 0xDDDDCCCC, each with sorted_valid.
//  3. bw=10, num=2, pe_ready low 2 cycles during phase 2:
//     - mux_state holds at 2;
//     - sorted_valid low for those 2 cycles;
//     - 8 valid pulses in total.
//  4. num=0 start:
//     - done pulses 2 cycles after start;
//     - buf_rd_en never asserts.
//  5. base=0xFF, num=2:
//     - addresses 0xFF then 0x00.
//     - start pulse during busy is ignored: cfg unchanged, single done.
//  6. Assert reset low mid-ISSUE:
//     - all outputs 0 immediately, no done pulse;
//     - a new start then runs normally.

Source files
------------

// File: rtl/weight_mux_sequencer_if.sv
// Bundle between the weight mux sequencer, the weight buffer read port,
// the weight mux register and the PE array.
interface weight_mux_sequencer_if #(
  parameter int ADDR_W = 8
);
  // Tile config: sampled only on a start pulse while idle.
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] num_words;
  logic [1:0]        input_bitwidth;

  // Handshakes: buf_rd_en stays high with a stable buf_rd_addr until the cycle
  // buf_rd_valid is seen, and data is taken on that edge. A word is issued to
  // the PE array on every edge where the sequencer is issuing and pe_ready=1,
  // and sorted_valid marks the mux register output one cycle later.
  logic              buf_rd_en;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic              buf_rd_valid;
  logic [31:0]       buf_rd_data;

  logic [31:0]       mux_buffer;
  logic [1:0]        mux_state;
  logic [1:0]        mux_bitwidth;
  logic              pe_ready;
  logic              sorted_valid;

  logic              busy;
  logic              done;
  // FSM state: 0=IDLE 1=FETCH 2=ISSUE 3=DONE.
  logic [1:0]        dbg_state;

  modport slave (
    input  start, base_addr, num_words, input_bitwidth,
    input  buf_rd_valid, buf_rd_data, pe_ready,
    output buf_rd_en, buf_rd_addr, mux_buffer, mux_state, mux_bitwidth,
    output sorted_valid, busy, done, dbg_state
  );

  modport master (
    output start, base_addr, num_words, input_bitwidth,
    output buf_rd_valid, buf_rd_data, pe_ready,
    input  buf_rd_en, buf_rd_addr, mux_buffer, mux_state, mux_bitwidth,
    input  sorted_valid, busy, done, dbg_state
  );
endinterface

// File: rtl/weight_mux_sequencer.sv
// Fetches a weight tile word by word and steps the weight mux register
// through the phases its latched bitwidth needs, with PE backpressure.
module weight_mux_sequencer #(
  parameter int ADDR_W = 8
) (
  input logic                  clk,
  input logic                  reset,
  weight_mux_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] word_cnt;
  logic [ADDR_W-1:0] num_lat;
  logic [1:0]        bw_lat;
  logic [1:0]        phase;
  logic [31:0]       word_q;
  logic              sorted_valid_q;
  logic              done_q;

  logic issue;
  logic last_phase;
  logic last_word;

  assign issue      = (state == S_ISSUE) && bus.pe_ready;
  // 8b words need one phase, 4b two, 2b four.
  assign last_phase = (bw_lat == 2'b00) ? 1'b1 :
                      (bw_lat == 2'b01) ? (phase == 2'd1) : (phase == 2'd3);
  assign last_word  = (word_cnt == num_lat - ADDR_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      addr           <= '0;
      word_cnt       <= '0;
      num_lat        <= '0;
      bw_lat         <= 2'b00;
      phase          <= 2'd0;
      word_q         <= '0;
      sorted_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      // Mux register has one cycle of latency; done trails the DONE state.
      sorted_valid_q <= issue;
      done_q         <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            bw_lat   <= bus.input_bitwidth;
            num_lat  <= bus.num_words;
            addr     <= bus.base_addr;
            word_cnt <= '0;
            state    <= (bus.num_words == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (bus.buf_rd_valid) begin
            word_q <= bus.buf_rd_data;
            phase  <= 2'd0;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.pe_ready) begin
            if (!last_phase) begin
              phase <= phase + 2'd1;
            end else if (!last_word) begin
              addr     <= addr + ADDR_W'(1);
              word_cnt <= word_cnt + ADDR_W'(1);
              state    <= S_FETCH;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.buf_rd_en    = (state == S_FETCH);
  assign bus.buf_rd_addr  = addr;
  assign bus.mux_buffer   = word_q;
  assign bus.mux_state    = phase;
  assign bus.mux_bitwidth = bw_lat;
  assign bus.sorted_valid = sorted_valid_q;
  assign bus.busy         = (state != S_IDLE);
  assign bus.done         = done_q;
  assign bus.dbg_state    = state;
endmodule

// File: tb/tb_weight_mux_sequencer.sv
// Bench for weight_mux_sequencer: random tiles against a queue-based
// reference of expected (phase, word) issues and buffer read addresses.
module tb_weight_mux_sequencer;
  logic clk;
  logic reset;

  weight_mux_sequencer_if #(.ADDR_W(8)) bus ();

  weight_mux_sequencer #(.ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int read_lat = 1;
  int ready_mode = 0;
  int stall_used = 0;
  int rd_wait = 0;
  bit rd_active = 0;

  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];
  logic [7:0]  addr_q[$];
  logic [31:0] tile_words[$];
  logic [33:0] prev_obs;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endfunction

  function automatic logic [31:0] sort4(input logic [31:0] w, input logic [1:0] ph);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = w[16*ph +: 8];
    hi = w[16*ph+8 +: 8];
    return {hi, hi, lo, lo};
  endfunction

  function automatic logic [47:0] all_outputs();
    return {bus.buf_rd_en, bus.buf_rd_addr, bus.mux_buffer, bus.mux_state,
            bus.mux_bitwidth, bus.sorted_valid, bus.busy, bus.done};
  endfunction

  // weight buffer model with programmable read latency
  initial begin : mem_model
    forever begin
      @(negedge clk);
      bus.buf_rd_data = $urandom;
      if (!reset) begin
        rd_active = 0;
        bus.buf_rd_valid = 1'b0;
      end else if (bus.buf_rd_valid) begin
        bus.buf_rd_valid = 1'b0;
        rd_active = 0;
      end else if (bus.buf_rd_en) begin
        if (!rd_active) begin
          rd_active = 1;
          rd_wait = read_lat;
          rd_cnt++;
          if (addr_q.size() == 0) note_fail("unexpected_read");
          else check("rd_addr", 64'(bus.buf_rd_addr), 64'(addr_q.pop_front()));
        end else begin
          rd_wait--;
          if (rd_wait <= 0) begin
            bus.buf_rd_valid = 1'b1;
            bus.buf_rd_data = (tile_words.size() != 0) ? tile_words.pop_front() : 32'h0;
          end
        end
      end
    end
  end

  // PE backpressure driver
  initial begin : ready_driver
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: bus.pe_ready = 1'b1;
        1: bus.pe_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (stall_used == 0 && bus.dbg_state == 2'd2 && bus.mux_state == 2'd2) begin
            bus.pe_ready = 1'b0;
            stall_used = 1;
          end else if (stall_used == 1) begin
            check("stall_hold_state", 64'(bus.mux_state), 64'd2);
            check("stall_valid_low", 64'(bus.sorted_valid), 64'd0);
            bus.pe_ready = 1'b0;
            stall_used = 2;
          end else begin
            bus.pe_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // scoreboard monitor: word/phase seen in the issue cycle, checked when valid
  initial begin : monitor
    logic [33:0] exp;
    prev_obs = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.sorted_valid) begin
          valid_cnt++;
          obs_q.push_back(prev_obs);
          if (exp_q.size() == 0) note_fail("unexpected_sorted_valid");
          else begin
            exp = exp_q.pop_front();
            check("sorted_issue", 64'(prev_obs), 64'(exp));
          end
        end
        if (bus.done) done_cnt++;
      end
      prev_obs = {bus.mux_state, bus.mux_buffer};
    end
  end

  task automatic pulse_start(input logic [7:0] base, input logic [7:0] num, input logic [1:0] bw);
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = base;
    bus.num_words = num;
    bus.input_bitwidth = bw;
    @(negedge clk);
    bus.start = 1'b0;
    bus.base_addr = 8'($urandom);
    bus.num_words = 8'($urandom);
    bus.input_bitwidth = 2'($urandom);
  endtask

  task automatic load_tile(input logic [7:0] base, input logic [7:0] num, input logic [1:0] bw,
                           input bit use_fixed, input logic [31:0] fixed_word);
    int p;
    logic [31:0] w;
    logic [7:0] a;
    p = (bw == 2'b00) ? 1 : (bw == 2'b01) ? 2 : 4;
    for (int i = 0; i < int'(num); i++) begin
      w = use_fixed ? fixed_word : $urandom;
      a = base + 8'(i);
      tile_words.push_back(w);
      addr_q.push_back(a);
      for (int ph = 0; ph < p; ph++) exp_q.push_back({2'(ph), w});
    end
  endtask

  task automatic run_tile(input logic [7:0] base, input logic [7:0] num, input logic [1:0] bw,
                          input int lat, input int mode, input bit poke,
                          input bit use_fixed, input logic [31:0] fixed_word);
    int p;
    int vc0;
    int dc0;
    int cyc;
    p = (bw == 2'b00) ? 1 : (bw == 2'b01) ? 2 : 4;
    read_lat = lat;
    ready_mode = mode;
    stall_used = 0;
    obs_q.delete();
    load_tile(base, num, bw, use_fixed, fixed_word);
    vc0 = valid_cnt;
    dc0 = done_cnt;
    pulse_start(base, num, bw);
    cyc = 0;
    while (done_cnt == dc0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 3) begin
        bus.start = 1'b1;
        bus.num_words = 8'd0;
        bus.base_addr = 8'($urandom);
        bus.input_bitwidth = 2'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    if (cyc >= 4000) note_fail("done_timeout");
    repeat (2) @(negedge clk);
    check("valid_count", 64'(valid_cnt - vc0), 64'(int'(num) * p));
    check("done_count", 64'(done_cnt - dc0), 64'd1);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("reads_drained", 64'(addr_q.size()), 64'd0);
    check("idle_after_tile", 64'(bus.busy), 64'd0);
    exp_q.delete();
    addr_q.delete();
    tile_words.delete();
  endtask

  initial begin : main
    int dc0;
    int rc0;
    int lat_seen;
    int cyc;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.num_words = '0;
    bus.input_bitwidth = '0;
    bus.buf_rd_valid = 1'b0;
    bus.buf_rd_data = '0;
    bus.pe_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(all_outputs()), 64'd0);
    check("reset_state", 64'(bus.dbg_state), 64'd0);
    reset = 1'b1;

    // 8b tile, three words at 0x10
    run_tile(8'h10, 8'd3, 2'b00, 1, 0, 0, 0, 32'h0);

    // 4b single word, mux register view of each phase
    run_tile(8'h40, 8'd1, 2'b01, 2, 0, 0, 1, 32'hDDCCBBAA);
    check("sorted_count_4b", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() == 2) begin
      check("sorted_4b_ph0", 64'(sort4(obs_q[0][31:0], obs_q[0][33:32])), 64'hBBBBAAAA);
      check("sorted_4b_ph1", 64'(sort4(obs_q[1][31:0], obs_q[1][33:32])), 64'hDDDDCCCC);
    end

    // 2b, two words, stall in phase 2
    run_tile(8'h80, 8'd2, 2'b10, 1, 2, 0, 0, 32'h0);
    check("stall_exercised", 64'(stall_used), 64'd2);

    // empty tile
    ready_mode = 0;
    dc0 = done_cnt;
    rc0 = rd_cnt;
    lat_seen = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_words = 8'd0;
    bus.base_addr = 8'h33;
    bus.input_bitwidth = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done && lat_seen == 0) lat_seen = k;
    end
    check("zero_done_latency", 64'(lat_seen), 64'd2);
    check("zero_done_count", 64'(done_cnt - dc0), 64'd1);
    check("zero_no_reads", 64'(rd_cnt - rc0), 64'd0);

    // address wrap plus a start pulse while busy
    run_tile(8'hFF, 8'd2, 2'($urandom_range(0, 3)), 3, 1, 1, 0, 32'h0);

    // reset mid-ISSUE
    ready_mode = 1;
    read_lat = 2;
    load_tile(8'h20, 8'd4, 2'b10, 0, 32'h0);
    pulse_start(8'h20, 8'd4, 2'b10);
    cyc = 0;
    while (bus.dbg_state != 2'd2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) note_fail("issue_timeout");
    dc0 = done_cnt;
    reset = 1'b0;
    #1;
    check("midtile_reset_outputs", 64'(all_outputs()), 64'd0);
    exp_q.delete();
    addr_q.delete();
    tile_words.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("midtile_reset_no_done", 64'(done_cnt - dc0), 64'd0);
    run_tile(8'h55, 8'd2, 2'b01, 1, 0, 0, 0, 32'h0);

    // random tiles
    for (int t = 0; t < 8; t++) begin
      run_tile(8'($urandom), 8'($urandom_range(1, 6)), 2'($urandom_range(0, 3)),
               $urandom_range(1, 4), 1, 0, 0, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
